alu_rs_scheduler: RTL and testbench
===================================

// Module: alu_rs_scheduler
// PURPOSE
// Reservation station and issue scheduler for the single shared ALU. Accepts decoded ops from
// dispatch, holds them until both operands are resolved by snooping the ALU and LSB result
// broadcasts, and issues at most one ready op per cycle to the ALU. It owns the ALU's
// execute/type/val1/val2/entry/nowPC inputs. Cleared on ROB flush (branch/JALR mispredict).
// PARAMETERS
// RS_DEPTH   16  number of station entries (power of 2, >=2)
// ROB_ID_W   5   ROB tag width; matches ALU entry port width
// OP_W       7   op type width; [2:0] class, [5:3] funct3, [6] variant bit
// VAL_W      32  operand/result width
// ADDR_W     32  PC width
// PORTS
// clk          in   1        clock
// rst_in       in   1        synchronous active-high reset
// rdy_in       in   1        global enable; 0 freezes all state
// flush        in   1        ROB mispredict: discard all entries
// disp_valid   in   1        dispatch op present
// disp_type    in   OP_W     op type
// disp_vj/vk   in   VAL_W    operand values (meaningful when qj_v/qk_v=0)
// disp_qj/qk   in   ROB_ID_W producer tags
// disp_qj_v    in   1        1 = operand 1 waiting on disp_qj (likewise disp_qk_v)
// disp_entry   in   ROB_ID_W destination ROB tag
// disp_pc      in   ADDR_W   PC of op (JALR link / AUIPC)
// rs_full      out  1        no free entry; dispatch must not assert disp_valid
// alu_ready    in   1        ALU broadcast valid; alu_entry ROB_ID_W, alu_val VAL_W
// lsb_ready    in   1        LSB broadcast valid; lsb_entry ROB_ID_W, lsb_val VAL_W
// execute      out  1        issue strobe to ALU
// type         out  OP_W     issued op
// val1/val2    out  VAL_W    issued operands
// entry        out  ROB_ID_W issued ROB tag
// nowPC        out  ADDR_W   issued PC
// BEHAVIOUR
// - Reset (sync, priority over all): all entries invalid; execute,type,val1,val2,entry,nowPC=0.
// - rdy_in=0 (no reset): no state change; outputs hold; broadcasts that cycle are ignored.
// - Per entry: busy, type, vj, vk, qj, qk, qj_v, qk_v, dest, pc. Ready = busy & !qj_v & !qk_v.
// - rs_full = combinational (count of busy == RS_DEPTH); a same-cycle issue does NOT clear it.
// - Dispatch: disp_valid & !rs_full writes lowest-index free entry at edge. disp_valid while
//   full is a protocol error: dropped, no state change.
// - Dispatch bypass: if disp_qj_v and (alu_ready & alu_entry==disp_qj or lsb_ready &
//   lsb_entry==disp_qj) the same cycle, store value, qj_v=0. Same for qk. ALU wins if both match.
// - Wakeup: each cycle every busy entry with qj_v and matching broadcast tag captures value,
//   clears qj_v (qk likewise). Both ports may wake different operands in the same cycle.
// - Select: lowest-index ready entry, judged on state at start of cycle (a wakeup or dispatch
//   this cycle is visible next cycle). Latency: dispatch edge t -> earliest execute=1 in cycle
//   t+2 when operands are ready at dispatch.
// - Issue: at edge, registered outputs load selected entry, execute=1, entry busy cleared.
//   No ready entry: execute=0, other outputs hold last value. Freed slot reusable next cycle.
// - One issue per cycle; execute is a one-cycle pulse per op, may be high back-to-back.
// - Flush (rdy_in=1): all busy cleared, execute=0 at that edge; same-cycle dispatch discarded;
//   flush beats select and dispatch.
// - No reordering by age beyond index priority; starvation-free only because ops leave once ready.
// TESTING
// 1 Reset then dispatch ADDI (qj_v=qk_v=0, vj=5, vk=7, entry=3) -> execute=1 exactly 2 cycles
//   later, val1=5, val2=7, entry=3, then execute=0.
// 2 Dispatch op with qj=4 waiting; 3 cycles later alu_ready, alu_entry=4, alu_val=0x10 ->
//   execute next+1 cycle with val1=0x10; lsb broadcast of tag 4 earlier leaves it untouched if tag 5.
// 3 Same-cycle bypass: disp_qj_v=1, qj=2 with lsb_ready,lsb_entry=2,lsb_val=9 -> issue val1=9,
//   no hang.
// 4 Fill 16 entries all waiting -> rs_full=1, 17th disp_valid dropped; broadcast frees all ->
//   16 consecutive execute pulses in index order; rs_full drops after first issue.
// 5 Flush with 5 busy entries and concurrent dispatch -> no execute afterwards, rs_full=0,
//   later broadcasts cause nothing.
// 6 rdy_in=0 for 3 cycles with a ready entry -> outputs frozen; issue resumes on rdy_in=1.

Source files
------------

// File: rtl/alu_rs_scheduler_if.sv
// Bundle of the scheduler's dispatch, result-broadcast and ALU-issue signals.
// The master side (dispatch/ALU/LSB) drives the requests; the slave side is the station.
interface alu_rs_scheduler_if #(
  parameter int ROB_ID_W = 5,
  parameter int OP_W     = 7,
  parameter int VAL_W    = 32,
  parameter int ADDR_W   = 32
);
  logic                disp_valid;
  logic [OP_W-1:0]     disp_type;
  logic [VAL_W-1:0]    disp_vj;
  logic [VAL_W-1:0]    disp_vk;
  logic [ROB_ID_W-1:0] disp_qj;
  logic [ROB_ID_W-1:0] disp_qk;
  logic                disp_qj_v;
  logic                disp_qk_v;
  logic [ROB_ID_W-1:0] disp_entry;
  logic [ADDR_W-1:0]   disp_pc;
  logic                rs_full;

  logic                alu_ready;
  logic [ROB_ID_W-1:0] alu_entry;
  logic [VAL_W-1:0]    alu_val;
  logic                lsb_ready;
  logic [ROB_ID_W-1:0] lsb_entry;
  logic [VAL_W-1:0]    lsb_val;

  // Issue side; the op type is called op_type because "type" is a reserved word.
  logic                execute;
  logic [OP_W-1:0]     op_type;
  logic [VAL_W-1:0]    val1;
  logic [VAL_W-1:0]    val2;
  logic [ROB_ID_W-1:0] entry;
  logic [ADDR_W-1:0]   nowPC;

  modport master (
    output disp_valid, disp_type, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_v, disp_qk_v, disp_entry, disp_pc,
           alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
    input  rs_full, execute, op_type, val1, val2, entry, nowPC
  );

  modport slave (
    input  disp_valid, disp_type, disp_vj, disp_vk, disp_qj, disp_qk,
           disp_qj_v, disp_qk_v, disp_entry, disp_pc,
           alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
    output rs_full, execute, op_type, val1, val2, entry, nowPC
  );
endinterface

// File: rtl/alu_rs_scheduler.sv
// Reservation station for the shared ALU: holds dispatched ops, snoops ALU/LSB result
// broadcasts for missing operands and issues the lowest-index ready op once per cycle.
module alu_rs_scheduler #(
  parameter int RS_DEPTH = 16,
  parameter int ROB_ID_W = 5,
  parameter int OP_W     = 7,
  parameter int VAL_W    = 32,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  alu_rs_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);

  logic                busy_q [RS_DEPTH];
  logic                qj_v_q [RS_DEPTH];
  logic                qk_v_q [RS_DEPTH];
  logic [OP_W-1:0]     type_q [RS_DEPTH];
  logic [VAL_W-1:0]    vj_q   [RS_DEPTH];
  logic [VAL_W-1:0]    vk_q   [RS_DEPTH];
  logic [ROB_ID_W-1:0] qj_q   [RS_DEPTH];
  logic [ROB_ID_W-1:0] qk_q   [RS_DEPTH];
  logic [ROB_ID_W-1:0] dest_q [RS_DEPTH];
  logic [ADDR_W-1:0]   pc_q   [RS_DEPTH];

  logic                execute_q;
  logic [OP_W-1:0]     op_type_q;
  logic [VAL_W-1:0]    val1_q;
  logic [VAL_W-1:0]    val2_q;
  logic [ROB_ID_W-1:0] entry_q;
  logic [ADDR_W-1:0]   now_pc_q;

  logic                full;
  logic                sel_valid;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    free_idx;
  logic                disp_we;
  logic [VAL_W-1:0]    disp_vj_d;
  logic [VAL_W-1:0]    disp_vk_d;
  logic                disp_qj_v_d;
  logic                disp_qk_v_d;

  // Scanning downwards leaves the lowest matching index in both select and free pointers.
  always_comb begin
    full      = 1'b1;
    sel_valid = 1'b0;
    sel_idx   = '0;
    free_idx  = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        full     = 1'b0;
        free_idx = IDX_W'(i);
      end
      if (busy_q[i] && !qj_v_q[i] && !qk_v_q[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign disp_we = bus.disp_valid && !full && !flush;

  // Operands produced in the dispatch cycle are captured directly; ALU result takes priority.
  always_comb begin
    disp_vj_d   = bus.disp_vj;
    disp_qj_v_d = bus.disp_qj_v;
    disp_vk_d   = bus.disp_vk;
    disp_qk_v_d = bus.disp_qk_v;
    if (bus.disp_qj_v) begin
      if (bus.alu_ready && bus.alu_entry == bus.disp_qj) begin
        disp_vj_d   = bus.alu_val;
        disp_qj_v_d = 1'b0;
      end else if (bus.lsb_ready && bus.lsb_entry == bus.disp_qj) begin
        disp_vj_d   = bus.lsb_val;
        disp_qj_v_d = 1'b0;
      end
    end
    if (bus.disp_qk_v) begin
      if (bus.alu_ready && bus.alu_entry == bus.disp_qk) begin
        disp_vk_d   = bus.alu_val;
        disp_qk_v_d = 1'b0;
      end else if (bus.lsb_ready && bus.lsb_entry == bus.disp_qk) begin
        disp_vk_d   = bus.lsb_val;
        disp_qk_v_d = 1'b0;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RS_DEPTH; gi++) begin : g_entry
      logic j_alu_hit, j_lsb_hit, k_alu_hit, k_lsb_hit;
      assign j_alu_hit = bus.alu_ready && bus.alu_entry == qj_q[gi];
      assign j_lsb_hit = bus.lsb_ready && bus.lsb_entry == qj_q[gi];
      assign k_alu_hit = bus.alu_ready && bus.alu_entry == qk_q[gi];
      assign k_lsb_hit = bus.lsb_ready && bus.lsb_entry == qk_q[gi];

      always_ff @(posedge clk) begin
        if (rst_in) begin
          busy_q[gi] <= 1'b0;
          qj_v_q[gi] <= 1'b0;
          qk_v_q[gi] <= 1'b0;
        end else if (rdy_in) begin
          if (flush) begin
            busy_q[gi] <= 1'b0;
          end else if (disp_we && free_idx == IDX_W'(gi)) begin
            busy_q[gi] <= 1'b1;
            type_q[gi] <= bus.disp_type;
            vj_q[gi]   <= disp_vj_d;
            vk_q[gi]   <= disp_vk_d;
            qj_q[gi]   <= bus.disp_qj;
            qk_q[gi]   <= bus.disp_qk;
            qj_v_q[gi] <= disp_qj_v_d;
            qk_v_q[gi] <= disp_qk_v_d;
            dest_q[gi] <= bus.disp_entry;
            pc_q[gi]   <= bus.disp_pc;
          end else begin
            if (sel_valid && sel_idx == IDX_W'(gi)) begin
              busy_q[gi] <= 1'b0;
            end
            if (busy_q[gi] && qj_v_q[gi] && (j_alu_hit || j_lsb_hit)) begin
              vj_q[gi]   <= j_alu_hit ? bus.alu_val : bus.lsb_val;
              qj_v_q[gi] <= 1'b0;
            end
            if (busy_q[gi] && qk_v_q[gi] && (k_alu_hit || k_lsb_hit)) begin
              vk_q[gi]   <= k_alu_hit ? bus.alu_val : bus.lsb_val;
              qk_v_q[gi] <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  // Issue register: data outputs keep the last issued op when nothing is ready.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      execute_q <= 1'b0;
      op_type_q <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      entry_q   <= '0;
      now_pc_q  <= '0;
    end else if (rdy_in) begin
      if (flush || !sel_valid) begin
        execute_q <= 1'b0;
      end else begin
        execute_q <= 1'b1;
        op_type_q <= type_q[sel_idx];
        val1_q    <= vj_q[sel_idx];
        val2_q    <= vk_q[sel_idx];
        entry_q   <= dest_q[sel_idx];
        now_pc_q  <= pc_q[sel_idx];
      end
    end
  end

  assign bus.rs_full = full;
  assign bus.execute = execute_q;
  assign bus.op_type = op_type_q;
  assign bus.val1    = val1_q;
  assign bus.val2    = val2_q;
  assign bus.entry   = entry_q;
  assign bus.nowPC   = now_pc_q;
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: expected issues are queued at stimulus time and
// popped by a monitor whenever a new execute pulse appears.
module tb_alu_rs_scheduler;
  logic clk = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b0;
  logic flush = 1'b0;

  alu_rs_scheduler_if #(.ROB_ID_W(5), .OP_W(7), .VAL_W(32), .ADDR_W(32)) bus ();

  alu_rs_scheduler #(.RS_DEPTH(16), .ROB_ID_W(5), .OP_W(7), .VAL_W(32), .ADDR_W(32)) dut (
    .clk    (clk),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  ty;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  e;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   issues = 0;
  int   cyc = 0;
  int   last_issue_cyc = -1;
  logic rdy_at_edge = 1'b0;
  logic rst_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rdy_at_edge <= rdy_in;
    rst_at_edge <= rst_in;
  end

  // A new issue is an execute pulse produced by an enabled, non-reset edge.
  always @(negedge clk) begin
    if (!rst_at_edge && rdy_at_edge && bus.execute === 1'b1) begin
      exp_t e;
      issues++;
      last_issue_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_issue got entry=%0d val1=%h val2=%h required no issue",
                 bus.entry, bus.val1, bus.val2);
      end else begin
        e = exp_q.pop_front();
        if (bus.op_type !== e.ty || bus.val1 !== e.v1 || bus.val2 !== e.v2 ||
            bus.entry !== e.e || bus.nowPC !== e.pc) begin
          failures++;
          $display("FAIL issue_fields got ty=%h v1=%h v2=%h e=%0d pc=%h required ty=%h v1=%h v2=%h e=%0d pc=%h",
                   bus.op_type, bus.val1, bus.val2, bus.entry, bus.nowPC,
                   e.ty, e.v1, e.v2, e.e, e.pc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.disp_valid = 1'b0;
    bus.disp_qj_v  = 1'b0;
    bus.disp_qk_v  = 1'b0;
    bus.alu_ready  = 1'b0;
    bus.lsb_ready  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic drive_disp(input logic [6:0] ty, input logic [31:0] vj, input logic [31:0] vk,
                            input logic [4:0] qj, input logic [4:0] qk, input logic qjv,
                            input logic qkv, input logic [4:0] e, input logic [31:0] pc);
    bus.disp_valid = 1'b1;
    bus.disp_type  = ty;
    bus.disp_vj    = vj;
    bus.disp_vk    = vk;
    bus.disp_qj    = qj;
    bus.disp_qk    = qk;
    bus.disp_qj_v  = qjv;
    bus.disp_qk_v  = qkv;
    bus.disp_entry = e;
    bus.disp_pc    = pc;
  endtask

  task automatic dispatch(input logic [6:0] ty, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [4:0] qj, input logic [4:0] qk, input logic qjv,
                          input logic qkv, input logic [4:0] e, input logic [31:0] pc);
    drive_disp(ty, vj, vk, qj, qk, qjv, qkv, e, pc);
    step();
    clear_inputs();
  endtask

  task automatic bcast(input logic av, input logic [4:0] ae, input logic [31:0] aval,
                       input logic lv, input logic [4:0] le, input logic [31:0] lval);
    bus.alu_ready = av;
    bus.alu_entry = ae;
    bus.alu_val   = aval;
    bus.lsb_ready = lv;
    bus.lsb_entry = le;
    bus.lsb_val   = lval;
    step();
    clear_inputs();
  endtask

  task automatic wait_issues(input int target, input int budget, input string name);
    for (int i = 0; i < budget && issues < target; i++) step();
    checks++;
    if (issues < target) begin
      failures++;
      $display("FAIL %s_timeout got issues=%0d required %0d", name, issues, target);
    end
  endtask

  task automatic check_latency(input int start, input int lat, input string name);
    checks++;
    if (last_issue_cyc - start !== lat) begin
      failures++;
      $display("FAIL %s_latency got %0d required %0d", name, last_issue_cyc - start, lat);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.disp_type = '0; bus.disp_vj = '0; bus.disp_vk = '0; bus.disp_qj = '0;
    bus.disp_qk = '0; bus.disp_entry = '0; bus.disp_pc = '0;
    bus.alu_entry = '0; bus.alu_val = '0; bus.lsb_entry = '0; bus.lsb_val = '0;
    rst_in = 1'b1;
    rdy_in = 1'b0;
    repeat (3) step();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    step();
    checks++;
    if (bus.execute !== 1'b0 || bus.op_type !== 7'd0 || bus.val1 !== 32'd0 ||
        bus.val2 !== 32'd0 || bus.entry !== 5'd0 || bus.nowPC !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got ex=%b ty=%h v1=%h v2=%h e=%0d pc=%h required all zero",
               bus.execute, bus.op_type, bus.val1, bus.val2, bus.entry, bus.nowPC);
    end
    checks++;
    if (bus.rs_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_rs_full got %b required 0", bus.rs_full);
    end
  endtask

  task automatic test_issue_basic();
    int k = cyc;
    int base = issues;
    exp_q.push_back('{ty: 7'h01, v1: 32'd5, v2: 32'd7, e: 5'd3, pc: 32'h100});
    dispatch(7'h01, 32'd5, 32'd7, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 32'h100);
    wait_issues(base + 1, 10, "basic");
    check_latency(k, 2, "basic");
    checks++;
    if (bus.execute !== 1'b0) begin
      failures++;
      $display("FAIL basic_pulse got execute=%b required 0", bus.execute);
    end
  endtask

  task automatic test_wakeup();
    int k;
    int base = issues;
    dispatch(7'h0B, 32'hFFFF_FFFF, 32'd3, 5'd4, 5'd0, 1'b1, 1'b0, 5'd6, 32'h200);
    step();
    bcast(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD);
    checks++;
    if (issues !== base) begin
      failures++;
      $display("FAIL wakeup_wrong_tag got issues=%0d required %0d", issues, base);
    end
    exp_q.push_back('{ty: 7'h0B, v1: 32'h10, v2: 32'd3, e: 5'd6, pc: 32'h200});
    k = cyc;
    bcast(1'b1, 5'd4, 32'h10, 1'b0, 5'd0, 32'd0);
    wait_issues(base + 1, 10, "wakeup");
    check_latency(k, 2, "wakeup");
  endtask

  task automatic test_bypass();
    int k = cyc;
    int base = issues;
    exp_q.push_back('{ty: 7'h0C, v1: 32'd9, v2: 32'h21, e: 5'd2, pc: 32'h300});
    drive_disp(7'h0C, 32'd0, 32'h21, 5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 32'h300);
    bcast(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'd9);
    wait_issues(base + 1, 10, "bypass_lsb");
    check_latency(k, 2, "bypass_lsb");
    exp_q.push_back('{ty: 7'h0D, v1: 32'h11, v2: 32'h11, e: 5'd8, pc: 32'h304});
    drive_disp(7'h0D, 32'd0, 32'd0, 5'd7, 5'd7, 1'b1, 1'b1, 5'd8, 32'h304);
    bcast(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    wait_issues(base + 2, 10, "bypass_alu_wins");
  endtask

  task automatic test_fill();
    int k;
    int base = issues;
    for (int i = 0; i < 16; i++)
      dispatch(7'h03, 32'd0, 32'(i * 3 + 1), 5'd9, 5'd0, 1'b1, 1'b0, 5'(i), 32'(32'h1000 + 4 * i));
    checks++;
    if (bus.rs_full !== 1'b1) begin
      failures++;
      $display("FAIL fill_rs_full got %b required 1", bus.rs_full);
    end
    dispatch(7'h7F, 32'hBAD, 32'hBAD, 5'd0, 5'd0, 1'b0, 1'b0, 5'd31, 32'hBAD);
    step();
    checks++;
    if (bus.rs_full !== 1'b1 || issues !== base) begin
      failures++;
      $display("FAIL fill_drop got rs_full=%b issues=%0d required 1 %0d", bus.rs_full, issues, base);
    end
    for (int i = 0; i < 16; i++)
      exp_q.push_back('{ty: 7'h03, v1: 32'h99, v2: 32'(i * 3 + 1), e: 5'(i), pc: 32'(32'h1000 + 4 * i)});
    k = cyc;
    bcast(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    checks++;
    if (bus.rs_full !== 1'b1) begin
      failures++;
      $display("FAIL fill_full_at_wakeup got %b required 1", bus.rs_full);
    end
    step();
    checks++;
    if (bus.rs_full !== 1'b0 || bus.execute !== 1'b1) begin
      failures++;
      $display("FAIL fill_first_issue got rs_full=%b execute=%b required 0 1", bus.rs_full, bus.execute);
    end
    wait_issues(base + 16, 40, "fill");
    check_latency(k, 17, "fill_back_to_back");
  endtask

  task automatic test_flush();
    int base = issues;
    for (int i = 0; i < 4; i++)
      dispatch(7'h04, 32'd0, 32'd1, 5'd12, 5'd0, 1'b1, 1'b0, 5'(20 + i), 32'h400);
    dispatch(7'h04, 32'd1, 32'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd24, 32'h410);
    drive_disp(7'h04, 32'd2, 32'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd25, 32'h414);
    flush = 1'b1;
    step();
    clear_inputs();
    checks++;
    if (bus.execute !== 1'b0 || bus.rs_full !== 1'b0) begin
      failures++;
      $display("FAIL flush_state got execute=%b rs_full=%b required 0 0", bus.execute, bus.rs_full);
    end
    bcast(1'b1, 5'd12, 32'h77, 1'b1, 5'd12, 32'h78);
    repeat (8) step();
    checks++;
    if (issues !== base) begin
      failures++;
      $display("FAIL flush_no_issue got issues=%0d required %0d", issues, base);
    end
  endtask

  task automatic test_freeze();
    int k;
    int base = issues;
    exp_q.push_back('{ty: 7'h05, v1: 32'hA1, v2: 32'hA2, e: 5'd13, pc: 32'h500});
    exp_q.push_back('{ty: 7'h06, v1: 32'hB1, v2: 32'hB2, e: 5'd14, pc: 32'h504});
    dispatch(7'h05, 32'hA1, 32'hA2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 32'h500);
    dispatch(7'h06, 32'hB1, 32'hB2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd14, 32'h504);
    rdy_in = 1'b0;
    drive_disp(7'h07, 32'hC1, 32'hC2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd15, 32'h508);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.execute !== 1'b1 || bus.entry !== 5'd13 || bus.val1 !== 32'hA1 ||
          bus.val2 !== 32'hA2 || bus.nowPC !== 32'h500) begin
        failures++;
        $display("FAIL freeze_hold got ex=%b e=%0d v1=%h v2=%h pc=%h required 1 13 a1 a2 500",
                 bus.execute, bus.entry, bus.val1, bus.val2, bus.nowPC);
      end
    end
    clear_inputs();
    rdy_in = 1'b1;
    k = cyc;
    wait_issues(base + 2, 10, "freeze_resume");
    check_latency(k, 1, "freeze_resume");
    repeat (4) step();
    checks++;
    if (issues !== base + 2) begin
      failures++;
      $display("FAIL freeze_dropped_disp got issues=%0d required %0d", issues, base + 2);
    end
  endtask

  initial begin
    test_reset();
    test_issue_basic();
    test_wakeup();
    test_bypass();
    test_fill();
    test_flush();
    test_freeze();
    repeat (3) step();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
